// File: rtl/risc_pkg.sv
// Shared RISC core definitions: instruction field layout, fetch/decode FSM
// encoding, skid entry and decoded-field structs.
package risc_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam int WORD_W   = 32;
  localparam int OPCODE_W = 6;
  localparam int REG_W    = 5;
  localparam int FUNCT_W  = 6;
  localparam int IMM_W    = 16;
  localparam int TARGET_W = 26;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_MSB = 25;
  localparam int TARGET_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fd_state_e;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    shamt;
    logic [FUNCT_W-1:0]  funct;
    logic [IMM_W-1:0]    imm;
    logic [TARGET_W-1:0] target;
  } insn_fields_t;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] pc;
  } fetch_ent_t;

endpackage

// File: rtl/insn_fields.sv
// Pure bit-slicing of an instruction word into its MIPS-style fields.
// Shared with the writeback/debug trace path.
module insn_fields
  import risc_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output insn_fields_t      fld
);

  always_comb begin
    fld        = '0;
    fld.opcode = word[OPCODE_MSB:OPCODE_LSB];
    fld.rs     = word[RS_MSB:RS_LSB];
    fld.rt     = word[RT_MSB:RT_LSB];
    fld.rd     = word[RD_MSB:RD_LSB];
    fld.shamt  = word[SHAMT_MSB:SHAMT_LSB];
    fld.funct  = word[FUNCT_MSB:FUNCT_LSB];
    fld.imm    = word[IMM_MSB:IMM_LSB];
    fld.target = word[TARGET_MSB:TARGET_LSB];
  end

endmodule

// File: rtl/fetch_decode_stage.sv
// Fetch/decode stage: PC-driven imem requests, decode register with a
// one-entry skid buffer for downstream stall, and branch redirect/flush.
module fetch_decode_stage
  import risc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [5:0]  id_opcode,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic [4:0]  id_shamt,
  output logic [5:0]  id_funct,
  output logic [15:0] id_imm,
  output logic [25:0] id_target
);

  fd_state_e    state, state_nx;
  logic [31:0]  pc, id_word;
  fetch_ent_t   skid;
  logic         skid_full;
  logic         accept, to_skid, bubble, unskid, redirect;
  insn_fields_t fld;

  // Branch wins over everything outside IDLE; a same-cycle ack is dropped.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    to_skid  = 1'b0;
    bubble   = 1'b0;
    unskid   = 1'b0;
    redirect = 1'b0;
    unique case (state)
      IDLE:  state_nx = FETCH;
      FETCH: begin
        if (branch_taken)                          redirect = 1'b1;
        else if (imem_ack && (!id_valid || !stall)) accept   = 1'b1;
        else if (imem_ack) begin
          to_skid  = 1'b1;
          state_nx = HOLD;
        end
        else if (!stall)                           bubble   = 1'b1;
      end
      HOLD: begin
        if (branch_taken) begin
          redirect = 1'b1;
          state_nx = FETCH;
        end else if (!stall) begin
          unskid   = skid_full;
          state_nx = FETCH;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= RESET_PC;
      id_valid  <= 1'b0;
      id_word   <= '0;
      id_pc     <= '0;
      id_pc4    <= '0;
      skid      <= '0;
      skid_full <= 1'b0;
    end else begin
      if (redirect)              pc <= {branch_target[31:2], 2'b00};
      else if (accept || to_skid) pc <= pc + 32'd4;

      if (redirect || bubble)    id_valid <= 1'b0;
      else if (accept || unskid) id_valid <= 1'b1;

      if (accept) begin
        id_word <= imem_data;
        id_pc   <= pc;
        id_pc4  <= pc + 32'd4;
      end else if (unskid) begin
        id_word <= skid.word;
        id_pc   <= skid.pc;
        id_pc4  <= skid.pc + 32'd4;
      end

      if (to_skid) begin
        skid      <= '{word: imem_data, pc: pc};
        skid_full <= 1'b1;
      end else if (redirect || unskid) begin
        skid_full <= 1'b0;
      end
    end
  end

  // Both derive only from registers, so they move on clock edges (or reset).
  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;

  insn_fields u_fields (
    .word (id_word),
    .fld  (fld)
  );

  assign id_opcode = fld.opcode;
  assign id_rs     = fld.rs;
  assign id_rt     = fld.rt;
  assign id_rd     = fld.rd;
  assign id_shamt  = fld.shamt;
  assign id_funct  = fld.funct;
  assign id_imm    = fld.imm;
  assign id_target = fld.target;

endmodule

// File: doc/fetch_decode_stage.md
# fetch_decode_stage

Fetch/decode pipeline stage for the RISC core. Drives instruction-memory requests from a local PC and latches returned words into a decode register. Slices each word into MIPS-style fields; `id_imm` feeds the 16-to-32 sign extender directly. Also handles downstream stall, with a one-entry skid buffer, and branch redirect/flush.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; low 2 bits must be 0.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  instruction fetch request.
- `imem_addr`  out  32  fetch address (current PC).
- `imem_ack`  in  1  `imem_data` is valid for this cycle's `imem_addr`.
- `imem_data`  in  32  instruction word.
- `stall`  in  1  downstream cannot accept a new decode-register value.
- `branch_taken`  in  1  redirect request.
- `branch_target`  in  32  redirect PC; bits [1:0] are ignored and forced to 0.
- `id_valid`  out  1  decode register holds a live instruction.
- `id_pc`  out  32  address of the held instruction.
- `id_pc4`  out  32  `id_pc` + 4, mod 2^32.
- `id_opcode`  out  6  word[31:26].
- `id_rs`  out  5  word[25:21].
- `id_rt`  out  5  word[20:16].
- `id_rd`  out  5  word[15:11].
- `id_shamt`  out  5  word[10:6].
- `id_funct`  out  6  word[5:0].
- `id_imm`  out  16  word[15:0]; goes to the sign extender.
- `id_target`  out  26  word[25:0].

## Operation
- The FSM has three states: IDLE, FETCH, HOLD.
- While `reset` is asserted:
  - state = IDLE, pc = `RESET_PC`.
  - `imem_req` = 0, `id_valid` = 0, all `id_*` = 0, skid buffer empty.
- IDLE goes to FETCH unconditionally on the first clock after reset deasserts.
- In FETCH, `imem_req` = 1 and `imem_addr` = pc. The memory may take any number of cycles; an address change restarts its access.
- Accept condition: `imem_ack` && (!`id_valid` || !`stall`).
  - On accept: the decode register loads word, pc, and pc+4; `id_valid` <= 1; pc <= pc+4.
- If `imem_ack` && `id_valid` && `stall`:
  - The word and its PC go into the skid buffer; pc <= pc+4.
  - State goes to HOLD.
- In HOLD, `imem_req` = 0. When `stall` falls, the decode register loads from the skid buffer, the skid empties, and state returns to FETCH.
- If !`imem_ack` && !`stall`, `id_valid` <= 0 (bubble).
- While `stall` && `id_valid`, all `id_*` outputs hold their values.
- `branch_taken` has the highest priority and acts in any state except IDLE:
  - pc <= {`branch_target`[31:2], 2'b00}; `id_valid` <= 0; skid buffer cleared; state <= FETCH.
  - An `imem_ack` in the same cycle is discarded.
  - `stall` is ignored for that cycle.
- Arithmetic: all PC additions are 32-bit modulo, so 32'hFFFF_FFFC + 4 = 0. Field slicing is pure bit selection with no sign handling.
- Reset mid-fetch or mid-hold aborts immediately; the in-flight word is lost.

## Timing
- `imem_addr` and `imem_req` are registered (Moore outputs) and change only on `clk` edges.
- Latency: ack in cycle N puts the instruction on `id_*` with `id_valid` = 1 in cycle N+1.
- Best-case throughput is one instruction per cycle with ack held high.
- Branch in cycle N gives: `imem_addr` = target in cycle N+1; `id_valid` = 0 in cycle N+1; the first target instruction is visible in N+2 at the earliest.
- Leaving HOLD: the skid word appears on `id_*` in the cycle after `stall` falls. `imem_req` reasserts in that same cycle.

## Structure
- Shared package `risc_pkg` holds:
  - field widths and bit-position constants (OPCODE_MSB, etc.);
  - the FSM state encoding, 2 bits: IDLE = 0, FETCH = 1, HOLD = 2;
  - the `RESET_PC` default.
- One sub-module, `insn_fields`: purely combinational slicing of a 32-bit word into the `id_*` fields. It is reused later by the writeback/debug trace.
- The skid buffer (word, pc, full flag) lives inline in this block.

## Test plan
- Reset release, `imem_ack` tied 1, data 32'h2008_FFFF:
  - `imem_req` = 0 during reset and in the IDLE cycle, then 1.
  - Cycle after first ack: `id_pc` = 0, `id_pc4` = 4, `id_opcode` = 6'h08, `id_rt` = 8, `id_imm` = 16'hFFFF.
- Ack held low for 3 cycles in FETCH:
  - `imem_addr` stays 0x0 and `id_valid` = 0 throughout.
  - On the 4th-cycle ack, the instruction appears next cycle.
- `stall` = 1 with `id_valid` = 1 and ack arriving for pc 0x8:
  - `id_*` hold the 0x4 instruction; state goes to HOLD; `imem_req` = 0.
  - Drop `stall`: `id_pc` = 0x8 next cycle and `imem_addr` = 0xC.
- `branch_taken` = 1, target 32'h0000_0103, ack and `stall` both high in the same cycle:
  - Next cycle: `id_valid` = 0, `imem_addr` = 0x100, skid empty.
- `RESET_PC` = 32'hFFFF_FFF8 with continuous acks: `imem_addr` sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert `reset` asynchronously mid-HOLD: `id_valid` and `imem_req` drop to 0 immediately, without waiting for a clock edge, and pc = `RESET_PC`.
